// File: rtl/avalon_hex_scroller_pkg.sv
// Shared constants for the hex scroller: slave register map, CTRL/STATUS bit
// positions, FSM states and the display peripheral's digit-register addresses.
package avalon_hex_scroller_pkg;

   localparam logic [2:0] ADDR_MSG_LO = 3'd0;
   localparam logic [2:0] ADDR_MSG_HI = 3'd1;
   localparam logic [2:0] ADDR_PERIOD = 3'd2;
   localparam logic [2:0] ADDR_CTRL   = 3'd3;
   localparam logic [2:0] ADDR_STATUS = 3'd4;

   localparam int CTRL_ENABLE  = 0;
   localparam int CTRL_DIR     = 1;
   localparam int CTRL_ONESHOT = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_POS_LSB = 4;

   localparam logic [2:0] DISP_ADDR_W0 = 3'd0;
   localparam logic [2:0] DISP_ADDR_W1 = 3'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WR0,
      ST_WR1,
      ST_WAIT
   } state_e;

endpackage

// File: rtl/hex_frame_rotator.sv
// Picks the 8-nibble window starting at POS out of the 16-nibble message,
// wrapping circularly; purely combinational.
module hex_frame_rotator
   import avalon_hex_scroller_pkg::*;
(
   input  logic [63:0] msg,
   input  logic [3:0]  pos,
   output logic [31:0] word0,
   output logic [31:0] word1
);

   logic [7:0][3:0] nib;

   for (genvar i = 0; i < 8; i++) begin : g_nib
      logic [3:0] idx;
      // 4-bit add gives the mod-16 wrap for free
      assign idx    = pos + 4'(i);
      assign nib[i] = msg[{idx, 2'b00} +: 4];
   end

   assign word0 = {16'h0, nib[3:0]};
   assign word1 = {16'h0, nib[7:4]};

endmodule

// File: rtl/avalon_hex_scroller.sv
// Avalon MM scroll controller: CPU-visible message/period/control registers and
// a master that rewrites display digit registers 0 and 1 once per scroll step.
module avalon_hex_scroller
   import avalon_hex_scroller_pkg::*;
#(
   parameter int unsigned DEFAULT_PERIOD = 50_000_000,
   parameter int          PERIOD_W       = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        chipselect,
   input  logic [2:0]  address,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic        read,
   output logic [31:0] readdata,
   output logic [2:0]  m_address,
   output logic        m_write,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest
);

   state_e              state_q, state_d;
   logic [31:0]         msg_lo_q, msg_lo_d;
   logic [31:0]         msg_hi_q, msg_hi_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [2:0]          ctrl_q, ctrl_d;
   logic                done_q, done_d;
   logic [3:0]          pos_q, pos_d;
   logic [31:0]         word0_q, word0_d;
   logic [31:0]         word1_q, word1_d;

   logic                wr_en, wr_ctrl, en_next, accepted, busy;
   logic                start, advance, finish, load_cnt;
   logic [3:0]          pos_step;
   logic [PERIOD_W-1:0] cnt_load;
   logic [31:0]         rot_w0, rot_w1, status_w;

   assign wr_en    = chipselect & write;
   assign wr_ctrl  = wr_en && (address == ADDR_CTRL);
   // A CTRL write in the same cycle overrides the stored enable
   assign en_next  = wr_ctrl ? writedata[CTRL_ENABLE] : ctrl_q[CTRL_ENABLE];
   assign accepted = ~m_waitrequest;
   assign busy     = (state_q != ST_IDLE);
   assign pos_step = ctrl_q[CTRL_DIR] ? pos_q - 4'd1 : pos_q + 4'd1;
   assign cnt_load = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

   hex_frame_rotator u_rot (
      .msg   ({msg_hi_q, msg_lo_q}),
      .pos   (pos_d),
      .word0 (rot_w0),
      .word1 (rot_w1)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         msg_lo_q <= '0;
         msg_hi_q <= '0;
         period_q <= PERIOD_W'(DEFAULT_PERIOD);
         cnt_q    <= '0;
         ctrl_q   <= '0;
         done_q   <= 1'b0;
         pos_q    <= '0;
         word0_q  <= '0;
         word1_q  <= '0;
      end else begin
         state_q  <= state_d;
         msg_lo_q <= msg_lo_d;
         msg_hi_q <= msg_hi_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         ctrl_q   <= ctrl_d;
         done_q   <= done_d;
         pos_q    <= pos_d;
         word0_q  <= word0_d;
         word1_q  <= word1_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      advance  = 1'b0;
      finish   = 1'b0;
      load_cnt = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_ctrl && writedata[CTRL_ENABLE]) begin
               state_d = ST_WR0;
               start   = 1'b1;
            end
         end
         ST_WR0: begin
            // a stalled write is always completed; disable only takes effect after it
            if (accepted) state_d = en_next ? ST_WR1 : ST_IDLE;
         end
         ST_WR1: begin
            if (accepted) begin
               if (en_next) begin
                  state_d  = ST_WAIT;
                  load_cnt = 1'b1;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            if (!en_next) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               advance = 1'b1;
               if (ctrl_q[CTRL_ONESHOT] && (pos_step == 4'd0)) begin
                  finish  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WR0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      msg_lo_d = msg_lo_q;
      msg_hi_d = msg_hi_q;
      period_d = period_q;
      ctrl_d   = ctrl_q;
      done_d   = done_q;
      pos_d    = pos_q;
      word0_d  = word0_q;
      word1_d  = word1_q;
      cnt_d    = cnt_q;

      if (wr_en) begin
         case (address)
            ADDR_MSG_LO: msg_lo_d = writedata;
            ADDR_MSG_HI: msg_hi_d = writedata;
            ADDR_PERIOD: period_d = writedata[PERIOD_W-1:0];
            ADDR_CTRL:   ctrl_d   = writedata[2:0];
            ADDR_STATUS: done_d   = 1'b0;
            default: ;
         endcase
      end

      // completion beats a concurrent STATUS clear and a concurrent enable write
      if (finish) begin
         done_d              = 1'b1;
         ctrl_d[CTRL_ENABLE] = 1'b0;
      end

      if (start)        pos_d = 4'd0;
      else if (advance) pos_d = pos_step;

      if (start || (advance && !finish)) begin
         word0_d = rot_w0;
         word1_d = rot_w1;
      end

      if (load_cnt)                                 cnt_d = cnt_load;
      else if (state_q == ST_WAIT && cnt_q != '0)   cnt_d = cnt_q - PERIOD_W'(1);
   end

   always_comb begin
      m_write     = 1'b0;
      m_address   = DISP_ADDR_W0;
      m_writedata = '0;
      case (state_q)
         ST_WR0: begin
            m_write     = 1'b1;
            m_address   = DISP_ADDR_W0;
            m_writedata = word0_q;
         end
         ST_WR1: begin
            m_write     = 1'b1;
            m_address   = DISP_ADDR_W1;
            m_writedata = word1_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      status_w                     = '0;
      status_w[STAT_BUSY]          = busy;
      status_w[STAT_DONE]          = done_q;
      status_w[STAT_POS_LSB +: 4]  = pos_q;

      readdata = '0;
      if (chipselect && read) begin
         case (address)
            ADDR_MSG_LO: readdata = msg_lo_q;
            ADDR_MSG_HI: readdata = msg_hi_q;
            ADDR_PERIOD: readdata = 32'(period_q);
            ADDR_CTRL:   readdata = {29'h0, ctrl_q};
            ADDR_STATUS: readdata = status_w;
            default:     readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_hex_scroller.sv
// Directed and randomized bench for avalon_hex_scroller; accepted master writes
// are collected and compared against frames computed from the message by arithmetic.
module tb_avalon_hex_scroller;

   localparam int unsigned DEF_PERIOD = 50_000_000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        chipselect = 1'b0;
   logic [2:0]  address = '0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic        read = 1'b0;
   logic [31:0] readdata;
   logic [2:0]  m_address;
   logic        m_write;
   logic [31:0] m_writedata;
   logic        m_waitrequest = 1'b0;

   avalon_hex_scroller dut (
      .clock         (clock),
      .reset         (reset),
      .chipselect    (chipselect),
      .address       (address),
      .write         (write),
      .writedata     (writedata),
      .read          (read),
      .readdata      (readdata),
      .m_address     (m_address),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_waitrequest (m_waitrequest)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic [2:0]  rec_addr[$];
   logic [31:0] rec_data[$];
   int          rec_cyc[$];
   int          rec_stall[$];
   int          stall_cnt = 0;
   bit          mon_en = 1'b1;
   bit          prev_stall = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Collect accepted writes; a stalled write must still be asserted next cycle.
   always @(negedge clock) begin
      if (mon_en && prev_stall) chk("hold_write", m_write, 1);
      prev_stall = mon_en && m_write && m_waitrequest;
      if (m_write && m_waitrequest) stall_cnt++;
      if (m_write && !m_waitrequest) begin
         rec_addr.push_back(m_address);
         rec_data.push_back(m_writedata);
         rec_cyc.push_back(cyc);
         rec_stall.push_back(stall_cnt);
      end
   end

   function automatic logic [31:0] frame_w(input logic [63:0] m, input int pos, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         int n;
         n = (pos + 4 * w + i) % 16;
         r = r | (32'((m >> (4 * n)) & 64'hF) << (4 * i));
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      chipselect = 1'b1; read = 1'b1; address = a;
      #1;
      v = readdata;
      chipselect = 1'b0; read = 1'b0; address = '0;
      tick();
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd(a, v);
      chk(tag, v, exp);
   endtask

   task automatic clear_recs();
      rec_addr.delete(); rec_data.delete(); rec_cyc.delete(); rec_stall.delete();
   endtask

   task automatic wait_recs(input int n, input bit rnd);
      int b;
      b = 0;
      while (rec_addr.size() < n && b < 3000) begin
         if (rnd) m_waitrequest = ($urandom_range(0, 3) == 0);
         tick();
         b++;
      end
      chk("wait_recs", rec_addr.size() >= n, 1);
   endtask

   // Frame k sits at POS +/-k; frames before n_a use message ma, later ones mb.
   task automatic check_run(input string tag, input int n, input bit dir, input int p,
                            input logic [63:0] ma, input logic [63:0] mb, input int n_a);
      chk($sformatf("%s_count", tag), rec_addr.size(), 2 * n);
      for (int k = 0; k < n && 2 * k + 1 < rec_addr.size(); k++) begin
         int pos;
         logic [63:0] m;
         pos = dir ? (16 - (k % 16)) % 16 : k % 16;
         m   = (k < n_a) ? ma : mb;
         chk($sformatf("%s_a0_%0d", tag, k), rec_addr[2*k], 0);
         chk($sformatf("%s_d0_%0d", tag, k), rec_data[2*k], frame_w(m, pos, 0));
         chk($sformatf("%s_a1_%0d", tag, k), rec_addr[2*k+1], 1);
         chk($sformatf("%s_d1_%0d", tag, k), rec_data[2*k+1], frame_w(m, pos, 1));
         chk($sformatf("%s_gap01_%0d", tag, k), rec_cyc[2*k+1] - rec_cyc[2*k],
             1 + rec_stall[2*k+1] - rec_stall[2*k]);
         if (k > 0)
            chk($sformatf("%s_period_%0d", tag, k), rec_cyc[2*k] - rec_cyc[2*k-2],
                p + 2 + rec_stall[2*k] - rec_stall[2*k-2]);
      end
   endtask

   initial begin
      logic [63:0] msg, msg2;
      logic [31:0] v, new_lo;
      int t0, p, n, b;
      bit dir;

      msg = 64'hFEDCBA98_76543210;

      // reset state
      repeat (3) tick();
      chk("rst_mwrite", m_write, 0);
      chk("rst_maddr", m_address, 0);
      chk("rst_mdata", m_writedata, 0);
      reset = 1'b1;
      tick();
      chk_reg("rst_msg_lo", 3'd0, 0);
      chk_reg("rst_msg_hi", 3'd1, 0);
      chk_reg("rst_period", 3'd2, DEF_PERIOD);
      chk_reg("rst_ctrl", 3'd3, 0);
      chk_reg("rst_status", 3'd4, 0);
      for (int a = 5; a < 8; a++) begin
         bus_wr(3'(a), 32'hFFFF_FFFF);
         chk_reg($sformatf("rsvd_%0d", a), 3'(a), 0);
      end

      // basic forward scroll out to POS 9
      clear_recs();
      bus_wr(3'd0, msg[31:0]);
      bus_wr(3'd1, msg[63:32]);
      bus_wr(3'd2, 4);
      chk_reg("period_rb", 3'd2, 4);
      bus_wr(3'd3, 1);
      t0 = cyc;
      wait_recs(20, 0);
      bus_wr(3'd3, 0);
      repeat (3) tick();
      check_run("basic", 10, 0, 4, msg, msg, 10);
      if (rec_data.size() >= 20) begin
         chk("basic_first_cyc", rec_cyc[0], t0);
         chk("basic_second_cyc", rec_cyc[2], t0 + 6);
         chk("basic_w0", rec_data[0], 32'h0000_3210);
         chk("basic_w1", rec_data[1], 32'h0000_7654);
         chk("wrap_w0", rec_data[18], 32'h0000_CBA9);
         chk("wrap_w1", rec_data[19], 32'h0000_0FED);
      end
      chk_reg("basic_status", 3'd4, 32'h90);

      // reverse direction
      clear_recs();
      bus_wr(3'd3, 3);
      wait_recs(8, 0);
      bus_wr(3'd3, 0);
      repeat (3) tick();
      check_run("dir", 4, 1, 4, msg, msg, 4);
      if (rec_data.size() >= 4) begin
         chk("dir_w0", rec_data[2], 32'h0000_210F);
         chk("dir_w1", rec_data[3], 32'h0000_6543);
      end
      chk_reg("dir_status", 3'd4, 32'hD0);

      // oneshot: one full lap then stop
      clear_recs();
      bus_wr(3'd2, 1);
      bus_wr(3'd3, 5);
      b = 0;
      do begin
         rd(3'd4, v);
         b++;
      end while (v[0] && b < 500);
      chk("oneshot_idle", v[0], 0);
      repeat (3) tick();
      check_run("one", 16, 0, 1, msg, msg, 16);
      chk_reg("one_status", 3'd4, 32'h2);
      chk_reg("one_ctrl", 3'd3, 32'h4);
      bus_wr(3'd4, 0);
      chk_reg("one_clear", 3'd4, 0);

      // waitrequest held for 3 cycles in the first WR0
      clear_recs();
      bus_wr(3'd2, 2);
      m_waitrequest = 1'b1;
      bus_wr(3'd3, 1);
      t0 = cyc;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) m_waitrequest = 1'b0;
         chk($sformatf("stall_wr_%0d", i), m_write, 1);
         chk($sformatf("stall_ad_%0d", i), m_address, 0);
         chk($sformatf("stall_dt_%0d", i), m_writedata, frame_w(msg, 0, 0));
         if (i < 3) tick();
      end
      wait_recs(4, 0);
      bus_wr(3'd3, 0);
      repeat (3) tick();
      check_run("stall", 2, 0, 2, msg, msg, 2);
      if (rec_cyc.size() >= 4) begin
         chk("stall_w0_cyc", rec_cyc[0], t0 + 3);
         chk("stall_next_cyc", rec_cyc[2], t0 + 3 + 4);
      end

      // disable while WR0 stalled
      clear_recs();
      m_waitrequest = 1'b1;
      bus_wr(3'd3, 1);
      bus_wr(3'd3, 0);
      tick();
      m_waitrequest = 1'b0;
      repeat (6) tick();
      chk("dis_count", rec_addr.size(), 1);
      if (rec_addr.size() >= 1) begin
         chk("dis_addr", rec_addr[0], 0);
         chk("dis_data", rec_data[0], frame_w(msg, 0, 0));
      end
      chk_reg("dis_status", 3'd4, 0);

      // randomized runs with random stalls and a mid-scroll message change
      for (int r = 0; r < 4; r++) begin
         msg2   = {$urandom, $urandom};
         p      = $urandom_range(2, 6);
         dir    = 1'($urandom_range(0, 1));
         n      = $urandom_range(3, 6);
         new_lo = $urandom;
         clear_recs();
         bus_wr(3'd0, msg2[31:0]);
         bus_wr(3'd1, msg2[63:32]);
         bus_wr(3'd2, 32'(p));
         bus_wr(3'd3, {30'h0, dir, 1'b1});
         wait_recs(2, 1);
         bus_wr(3'd0, new_lo);
         wait_recs(2 * n, 1);
         bus_wr(3'd3, 0);
         m_waitrequest = 1'b0;
         repeat (3) tick();
         check_run($sformatf("rnd%0d", r), n, dir, p, msg2, {msg2[63:32], new_lo}, 1);
         chk_reg($sformatf("rnd%0d_busy", r), 3'd4, {24'h0, 4'(dir ? 16 - (n - 1) : n - 1), 4'h0});
      end

      // reset during WR1
      bus_wr(3'd0, msg[31:0]);
      bus_wr(3'd2, 3);
      bus_wr(3'd3, 1);
      b = 0;
      while (!(m_write && m_address == 3'd1) && b < 50) begin
         tick();
         b++;
      end
      chk("saw_wr1", m_write && m_address == 3'd1, 1);
      mon_en = 1'b0;
      reset = 1'b0;
      tick();
      chk("rst2_mwrite", m_write, 0);
      chk("rst2_mdata", m_writedata, 0);
      reset = 1'b1;
      tick();
      mon_en = 1'b1;
      chk_reg("rst2_period", 3'd2, DEF_PERIOD);
      chk_reg("rst2_ctrl", 3'd3, 0);
      chk_reg("rst2_msg_lo", 3'd0, 0);
      chk_reg("rst2_msg_hi", 3'd1, 0);
      chk_reg("rst2_status", 3'd4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/avalon_hex_scroller.md
# avalon_hex_scroller

Scroll controller for the Avalon 8-digit 7-segment display peripheral. It holds a 64-bit (16-nibble) message written by the CPU through an Avalon MM slave port. Through an Avalon MM master port it periodically rewrites the peripheral's digit registers 0 and 1, so an 8-digit window moves across the message circularly. It sits in the Qsys system between the CPU data master and the display slave.

## Interface
- `DEFAULT_PERIOD`, 50_000_000: reset value of PERIOD, in clock cycles per scroll step.
- `PERIOD_W`, 32: width of PERIOD and of the tick counter.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `chipselect`  in  1  slave select.
- `address`  in  3  slave word address.
- `write`  in  1  slave write strobe.
- `writedata`  in  32  slave write data.
- `read`  in  1  slave read strobe.
- `readdata`  out  32  slave read data; combinational mux of `address`, zero-latency.
- `m_address`  out  3  master word address toward the display slave (0 or 1).
- `m_write`  out  1  master write strobe.
- `m_writedata`  out  32  master write data.
- `m_waitrequest`  in  1  display slave stall.

## Operation
- Slave registers:
  - 0 MSG_LO (nibbles 0–7), RW.
  - 1 MSG_HI (nibbles 8–15), RW.
  - 2 PERIOD, RW.
  - 3 CTRL, RW: bit0 ENABLE, bit1 DIR (0 = position increments, 1 = decrements), bit2 ONESHOT.
  - 4 STATUS, RO: bit0 BUSY, bit1 DONE, bits[7:4] POS. Any write to address 4 clears DONE.
  - Addresses 5–7 read 0; writes to them are ignored.
- Nibble n = message bits [4n+3:4n]. POS is 4 bits, 0–15; increment and decrement wrap modulo 16.
- Frame at POS p:
  - word0 = {16'h0, nib(p+3), nib(p+2), nib(p+1), nib(p)}.
  - word1 = {16'h0, nib(p+7) … nib(p+4)}.
  - All indices are taken mod 16.
- FSM states: IDLE, WR0, WR1, WAIT.
  - IDLE: a CTRL write with ENABLE=1 sets POS=0 and latches word0/word1 from the current message → WR0.
  - WR0: `m_address`=0, `m_write`=1, `m_writedata`=word0. Held until a cycle with `m_waitrequest`=0 → WR1.
  - WR1: same with address 1 and word1. On acceptance → WAIT, with the tick counter loaded to max(PERIOD,1)−1.
  - WAIT: the counter decrements each cycle. At 0, POS advances per DIR.
    - If ONESHOT=1 and the new POS equals 0: set DONE, clear ENABLE → IDLE. No further frame is written.
    - Otherwise latch the new frame → WR0.
- BUSY = state ≠ IDLE.
- Writing ENABLE=0:
  - In WAIT: go to IDLE the next cycle.
  - In WR0/WR1: finish the current accepted write (Avalon rule: the strobe is never dropped while waitrequest=1), then go to IDLE.
- Writing ENABLE=1 while already BUSY has no restart effect. DIR and ONESHOT updates apply at the next step.
- A message write mid-scroll does not affect the frame in flight; it is picked up at the next latch.
- PERIOD is sampled only at the counter load.
- Simultaneous DONE-set and STATUS-write clear: set wins.
- Reset values:
  - `m_write`=0, `m_address`=0, `m_writedata`=0, `readdata` reflects registers.
  - MSG=0, CTRL=0, PERIOD=DEFAULT_PERIOD, DONE=0, POS=0, state IDLE.
  - Reset asserted mid-transaction drops `m_write` immediately.

## Timing
- CTRL enable write sampled at edge T → `m_write` with address 0 from T+1.
- With `m_waitrequest`=0:
  - address 0 accepted in cycle T+1, address 1 in T+2.
  - WAIT covers T+3 … T+2+P, where P = max(PERIOD,1).
  - Next WR0 at T+3+P, so the frame period is P+2 cycles.
- Each waitrequest-high cycle stretches the frame by one cycle.
- STATUS is updated the edge after the event; `readdata` shows it in the same cycle.

## Structure
- Package `avalon_hex_scroller_pkg` holds:
  - register offsets (ADDR_MSG_LO…ADDR_STATUS);
  - CTRL/STATUS bit indices;
  - FSM state enum;
  - display target addresses (0, 1).
- Sub-module `hex_frame_rotator`: combinational; inputs 64-bit message and 4-bit POS; outputs word0/word1.
- The top level holds registers, FSM and tick counter.

## Test plan
- Basic frame: MSG_LO=0x76543210, MSG_HI=0xFEDCBA98, PERIOD=4, CTRL=1, waitrequest=0 → writes (0,0x00003210),(1,0x00007654); 6 cycles later (0,0x00004321),(1,0x00008765).
- Wrap: continue to POS 9 → (0,0x0000CBA9),(1,0x00000FED). DIR=1 from POS 0 → POS 15 frame (0,0x0000210F),(1,0x00006543).
- Oneshot: CTRL=0x5, PERIOD=1 → exactly 16 frames, then IDLE with BUSY=0, DONE=1, POS=0. A write to STATUS clears DONE.
- Waitrequest: hold waitrequest=1 for 3 cycles during WR0 → `m_write`, `m_address`=0, and data stable for all 4 cycles; frame period grows by 3.
- Disable mid-write: CTRL=0 while WR0 is stalled → the write completes once waitrequest drops; WR1 is never issued; then IDLE.
- Reset: `reset`=0 during WR1 → `m_write`=0 the next cycle; PERIOD reads DEFAULT_PERIOD; CTRL, MSG and STATUS read 0.
